alu_seq: RTL and testbench

Sequential ALU that executes the 5-bit ALU control code and Sign bit produced by the CPU's ALU control decoder. It sits on the consumer side of that control interface. Operands and the control code are captured under a valid/ready handshake. Logic and arithmetic ops finish in one cycle; shifts run iteratively at one bit per cycle. The result is held under a second valid/ready handshake, which makes the block usable in the multi-cycle and pipelined CPU variants.

---
 rtl/alu_seq.sv | 134 +++++++++++++
 tb/tb_alu_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU executing the 5-bit ALU control code with valid/ready on both sides.
// Logic/arithmetic ops complete on the accept edge; shifts iterate one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALUCtrl,
  input  logic             Sign,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SLT = 5'b00111;
  localparam logic [4:0] OP_NOR = 5'b01000;
  localparam logic [4:0] OP_XOR = 5'b01001;
  localparam logic [4:0] OP_SLL = 5'b01010;
  localparam logic [4:0] OP_SRL = 5'b10000;
  localparam logic [4:0] OP_SRA = 5'b10001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic [4:0]       count_q;
  logic             shl_q;
  logic             sra_q;

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] diff_w;
  logic             lt_w;
  logic             is_shift_w;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_ovf_d;
  logic [WIDTH-1:0] shift_d;

  assign sum_w      = In1 + In2;
  assign diff_w     = In1 - In2;
  assign lt_w       = Sign ? ($signed(In1) < $signed(In2)) : (In1 < In2);
  assign is_shift_w = (ALUCtrl == OP_SLL) || (ALUCtrl == OP_SRL) || (ALUCtrl == OP_SRA);

  // Single-cycle result, used on the accept edge for every non-iterative case.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    case (ALUCtrl)
      OP_AND: alu_res_d = In1 & In2;
      OP_OR:  alu_res_d = In1 | In2;
      OP_NOR: alu_res_d = ~(In1 | In2);
      OP_XOR: alu_res_d = In1 ^ In2;
      OP_ADD: begin
        alu_res_d = sum_w;
        alu_ovf_d = Sign & (In1[WIDTH-1] == In2[WIDTH-1]) & (sum_w[WIDTH-1] != In1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_d = diff_w;
        alu_ovf_d = Sign & (In1[WIDTH-1] != In2[WIDTH-1]) & (diff_w[WIDTH-1] != In1[WIDTH-1]);
      end
      OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, lt_w};
      // Shift codes only take this path with a zero amount, so the value passes through.
      OP_SLL, OP_SRL, OP_SRA: alu_res_d = In2;
      default: alu_res_d = '0;
    endcase
  end

  always_comb begin
    if (shl_q) shift_d = {result_q[WIDTH-2:0], 1'b0};
    else       shift_d = {sra_q & result_q[WIDTH-1], result_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      shl_q    <= 1'b0;
      sra_q    <= 1'b0;
    end else begin
      // NOTE: all state updates use non-blocking assignment so every register sees pre-edge values.
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            shl_q <= (ALUCtrl == OP_SLL);
            sra_q <= (ALUCtrl == OP_SRA);
            if (is_shift_w && (In1[4:0] != 5'd0)) begin
              result_q <= In2;
              ovf_q    <= 1'b0;
              count_q  <= In1[4:0];
              state_q  <= S_SHIFT;
            end else begin
              result_q <= alu_res_d;
              ovf_q    <= alu_ovf_d;
              state_q  <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          result_q <= shift_d;
          count_q  <= count_q - 5'd1;
          if (count_q == 5'd1) state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Result    = result_q;
  assign Zero      = (result_q == '0);
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued at accept and
// compared when the DUT presents them, together with latency and handshake checks.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ALUCtrl;
  logic        Sign;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUCtrl  (ALUCtrl),
    .Sign     (Sign),
    .In1      (In1),
    .In2      (In2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .Zero     (Zero),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour written from the operation table, using wide signed math for overflow.
  function automatic exp_t model(input logic [4:0] c, input logic s, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb_v;
    longint r;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    e.res = 32'h0;
    e.ovf = 1'b0;
    case (c)
      5'b00000: e.res = a & b;
      5'b00001: e.res = a | b;
      5'b00010: begin
        e.res = a + b;
        r = sa + sb_v;
        e.ovf = s && (r > 64'sd2147483647 || r < -64'sd2147483648);
      end
      5'b00110: begin
        e.res = a - b;
        r = sa - sb_v;
        e.ovf = s && (r > 64'sd2147483647 || r < -64'sd2147483648);
      end
      5'b00111: e.res = s ? {31'b0, sa < sb_v} : {31'b0, a < b};
      5'b01000: e.res = ~(a | b);
      5'b01001: e.res = a ^ b;
      5'b01010: e.res = b << a[4:0];
      5'b10000: e.res = b >> a[4:0];
      5'b10001: e.res = $signed(b) >>> a[4:0];
      default:  e.res = 32'h0;
    endcase
    return e;
  endfunction

  function automatic int exp_edges(input logic [4:0] c, input logic [31:0] a);
    if ((c == 5'b01010 || c == 5'b10000 || c == 5'b10001) && a[4:0] != 5'd0) return int'(a[4:0]);
    return 0;
  endfunction

  // Called at posedge+1 with in_ready high; returns at posedge+1 after the accept edge.
  task automatic send(input logic [4:0] c, input logic s, input logic [31:0] a, input logic [31:0] b);
    ALUCtrl  = c;
    Sign     = s;
    In1      = a;
    In2      = b;
    in_valid = 1'b1;
    sb.push_back(model(c, s, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALUCtrl  = 5'($urandom);
    Sign     = 1'($urandom);
    In1      = $urandom;
    In2      = $urandom;
  endtask

  // Counts edges after the accept edge until out_valid, then pops and compares.
  task automatic wait_result(input string tag, input int edges_exp);
    int   edges = 0;
    exp_t e;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_lat"}, 32'(edges), 32'(edges_exp));
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_res"}, Result, e.res);
      check({tag, "_ovf"}, 32'(Overflow), 32'(e.ovf));
      check({tag, "_zero"}, 32'(Zero), 32'(e.res == 32'h0));
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] c, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
    send(c, s, a, b);
    wait_result(tag, exp_edges(c, a));
    release_out(tag);
  endtask

  logic [4:0] ops [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111, 5'b01000,
                           5'b01001, 5'b01010, 5'b10000, 5'b10001, 5'b11111};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ALUCtrl   = 5'b0;
    Sign      = 1'b0;
    In1       = 32'h0;
    In2       = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", Result, 32'h0);
    check("rst_zero", 32'(Zero), 32'd1);
    check("rst_ovf", 32'(Overflow), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("add_s",  5'b00010, 1'b1, 32'h7FFF_FFFF, 32'h1);
    run_op("add_u",  5'b00010, 1'b0, 32'h7FFF_FFFF, 32'h1);
    run_op("slt_s",  5'b00111, 1'b1, 32'hFFFF_FFFF, 32'h1);
    run_op("slt_u",  5'b00111, 1'b0, 32'hFFFF_FFFF, 32'h1);
    run_op("sub_eq", 5'b00110, 1'b1, 32'd5, 32'd5);
    run_op("sub_ov", 5'b00110, 1'b1, 32'h8000_0000, 32'h1);
    run_op("sra4",   5'b10001, 1'b0, 32'd4, 32'h8000_0001);
    run_op("srl31",  5'b10000, 1'b1, 32'd31, 32'h8000_0001);
    run_op("sll0",   5'b01010, 1'b0, 32'd0, 32'h8000_0001);
    run_op("sll1",   5'b01010, 1'b0, 32'd1, 32'h8000_0001);
    run_op("undef",  5'b11111, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Backpressure: result must hold and new requests must be dropped.
    out_ready = 1'b0;
    send(5'b01001, 1'b0, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
    wait_result("bp", 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      ALUCtrl  = 5'b00010;
      In1      = 32'h1;
      In2      = 32'h1;
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_res", Result, 32'hAAAA_AAAA);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    @(posedge clk);
    #1;
    check("bp_no_queued", 32'(out_valid), 32'd0);

    // Reset in the middle of a long shift discards the operation.
    send(5'b01010, 1'b0, 32'd20, 32'h0000_0003);
    repeat (7) @(posedge clk);
    #1;
    check("abort_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(sb.pop_front());
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", Result, 32'h0);
    check("abort_zero", 32'(Zero), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", 32'(out_valid), 32'd0);
    run_op("post_abort_add", 5'b00010, 1'b0, 32'd2, 32'd3);

    // Random back-to-back traffic with occasional consumer stalls.
    for (int n = 0; n < 60; n++) begin
      logic [4:0]  c;
      logic [31:0] a;
      int          stall;
      c = ops[$urandom_range(0, 10)];
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[4:0] = 5'($urandom_range(0, 2));
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      out_ready = (stall == 0);
      send(c, 1'($urandom), a, $urandom);
      wait_result("rnd", exp_edges(c, a));
      repeat (stall) @(posedge clk);
      #1;
      release_out("rnd");
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
